// File: rtl/loop_delay_timer.sv
// Programmable period timer: counts enabled cycles and pulses o_yes once per period.
// Optional `LOOP_TICK_COUNT_EN adds a 16-bit wrapping count of o_yes pulses on o_tick_cnt.
module loop_delay_timer #(
  parameter int unsigned W = 65
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_strtcnt,
  input  logic         i_clr,
  input  logic [W-1:0] i_delay,
  input  logic [1:0]   i_speed,
  output logic         o_yes,
  output logic         o_busy,
`ifdef LOOP_TICK_COUNT_EN
  output logic [15:0]  o_tick_cnt,
`endif
  output logic [W-1:0] o_cnt
);

  typedef enum logic [1:0] {StIdle, StCount, StHold, StFire} state_e;

  localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};

  state_e       r_state, w_state_d;
  logic [W-1:0] r_cnt, w_cnt_d;
  logic [W-1:0] r_target, w_target_d;
  logic [W-1:0] w_shifted, w_tgt;

  // A zero period would never fire, so clamp the target to one cycle.
  assign w_shifted = i_delay >> i_speed;
  assign w_tgt     = (w_shifted == '0) ? One : w_shifted;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_target_d = r_target;
    if (i_clr) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      case (r_state)
        StIdle: begin
          w_cnt_d = '0;
          if (i_strtcnt) begin
            w_state_d  = StCount;
            w_cnt_d    = One;
            w_target_d = w_tgt;
          end
        end
        StCount: begin
          if (!i_strtcnt) begin
            w_state_d = StHold;
          end else if (r_cnt == r_target) begin
            w_state_d = StFire;
          end else begin
            w_cnt_d = r_cnt + One;
          end
        end
        StHold: begin
          if (i_strtcnt) begin
            w_state_d = StCount;
          end
        end
        StFire: begin
          w_cnt_d    = One;
          w_target_d = w_tgt;
          w_state_d  = i_strtcnt ? StCount : StHold;
        end
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_target <= One;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_target <= w_target_d;
    end
  end

`ifdef LOOP_TICK_COUNT_EN
  logic [15:0] r_tick_cnt;

  // Only reset clears the pulse count; clr restarts the period but keeps history.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_tick_cnt <= '0;
    end else if (r_state == StFire) begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  assign o_tick_cnt = r_tick_cnt;
`endif

  assign o_yes  = (r_state == StFire);
  assign o_busy = (r_state != StIdle);
  assign o_cnt  = r_cnt;

endmodule

// File: tb/tb_loop_delay_timer.sv
// Randomized and directed bench for loop_delay_timer against a behavioural period model.
module tb_loop_delay_timer;

  localparam int unsigned W = 65;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         strt;
  logic         clr;
  logic [W-1:0] delay;
  logic [1:0]   speed;
  logic         yes;
  logic         busy;
  logic [W-1:0] cnt;
`ifdef LOOP_TICK_COUNT_EN
  logic [15:0]  tick;
`endif

  always #5 clk = ~clk;

  loop_delay_timer #(.W(W)) u_dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_strtcnt (strt),
    .i_clr     (clr),
    .i_delay   (delay),
    .i_speed   (speed),
    .o_yes     (yes),
    .o_busy    (busy),
`ifdef LOOP_TICK_COUNT_EN
    .o_tick_cnt(tick),
`endif
    .o_cnt     (cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: running / held / firing flags plus progress within the period.
  bit           m_run;
  bit           m_hold;
  bit           m_fire;
  logic [W-1:0] m_cnt;
  logic [W-1:0] m_per;
  logic [15:0]  m_tick;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] period_of(input logic [W-1:0] d, input logic [1:0] s);
    logic [W-1:0] p;
    p = d / (W'(1) << s);
    return (p == 0) ? W'(1) : p;
  endfunction

  task automatic model_reset();
    m_run  = 0;
    m_hold = 0;
    m_fire = 0;
    m_cnt  = '0;
    m_per  = W'(1);
    m_tick = '0;
  endtask

  task automatic model_step();
    if (m_fire) m_tick = m_tick + 16'd1;
    if (clr) begin
      m_run  = 0;
      m_hold = 0;
      m_fire = 0;
      m_cnt  = '0;
    end else if (!m_run) begin
      m_cnt = '0;
      if (strt) begin
        m_run = 1;
        m_cnt = W'(1);
        m_per = period_of(delay, speed);
      end
    end else if (m_fire) begin
      m_fire = 0;
      m_cnt  = W'(1);
      m_per  = period_of(delay, speed);
      m_hold = !strt;
    end else if (m_hold) begin
      if (strt) m_hold = 0;
    end else if (!strt) begin
      m_hold = 1;
    end else if (m_cnt == m_per) begin
      m_fire = 1;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic compare_all();
    check_eq("yes", W'(yes), W'(m_fire));
    check_eq("busy", W'(busy), W'(m_run));
    check_eq("cnt", cnt, m_cnt);
`ifdef LOOP_TICK_COUNT_EN
    check_eq("tick_cnt", W'(tick), W'(m_tick));
`endif
  endtask

  // Called at a negedge with inputs set; returns at the next negedge with cyc advanced.
  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    strt  = 1'b0;
    clr   = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Runs n cycles with strt held and clr=0, recording which cycles showed yes.
  task automatic run_mask(input int n, output logic [31:0] mask);
    mask = '0;
    strt = 1'b1;
    clr  = 1'b0;
    for (int i = 0; i < n; i++) begin
      run_cycle();
      if (yes) mask[cyc] = 1'b1;
    end
  endtask

  logic [31:0] mask;

  initial begin
    rst_n = 1'b0;
    strt  = 1'b0;
    clr   = 1'b0;
    delay = '0;
    speed = '0;
    model_reset();
    @(negedge clk);
    check_eq("reset_yes", W'(yes), '0);
    check_eq("reset_busy", W'(busy), '0);
    check_eq("reset_cnt", cnt, '0);

    // 1: T=4
    do_reset();
    delay = W'(4);
    speed = 2'd0;
    run_mask(16, mask);
    check_eq("t1_yes_cycles", W'(mask), W'(32'h0000_8420));
`ifdef LOOP_TICK_COUNT_EN
    check_eq("t1_tick3", W'(tick), W'(3));
`endif

    // 2: speed scaling
    do_reset();
    delay = W'(8);
    speed = 2'd2;
    run_mask(9, mask);
    check_eq("t2a_yes_cycles", W'(mask), W'(32'h0000_0248));
    do_reset();
    speed = 2'd3;
    run_mask(6, mask);
    check_eq("t2b_yes_cycles", W'(mask), W'(32'h0000_0054));

    // 3: zero delay clamps to one
    do_reset();
    delay = '0;
    speed = 2'd0;
    strt  = 1'b1;
    run_cycle();
    check_eq("t3_busy_c1", W'(busy), W'(1));
    if (yes) mask[cyc] = 1'b1;
    mask = '0;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      if (yes) mask[cyc] = 1'b1;
    end
    check_eq("t3_yes_cycles", W'(mask), W'(32'h0000_0054));

    // 4: hold for cycles 2-4
    do_reset();
    delay = W'(4);
    mask  = '0;
    for (int i = 0; i < 10; i++) begin
      strt = !(cyc >= 2 && cyc <= 4);
      run_cycle();
      if (yes) mask[cyc] = 1'b1;
      if (cyc == 3) check_eq("t4_hold_cnt", cnt, W'(2));
    end
    check_eq("t4_yes_cycles", W'(mask), W'(32'h0000_0200));

    // 5: clr driven from yes
    do_reset();
    delay = W'(3);
    strt  = 1'b1;
    mask  = '0;
    for (int i = 0; i < 10; i++) begin
      clr = m_fire;
      run_cycle();
      if (yes) mask[cyc] = 1'b1;
      if (cyc == 5) check_eq("t5_cnt_after_clr", cnt, '0);
    end
    check_eq("t5_yes_cycles", W'(mask), W'(32'h0000_0210));
    clr = 1'b0;

    // 6: async reset mid-period
    do_reset();
    delay = W'(4);
    strt  = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle();
    check_eq("t6_cnt_before", cnt, W'(3));
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_async_yes", W'(yes), '0);
    check_eq("t6_async_busy", W'(busy), '0);
    check_eq("t6_async_cnt", cnt, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    run_mask(5, mask);
    check_eq("t6_yes_cycles", W'(mask), W'(32'h0000_0020));

    // Random traffic, including mid-period changes of delay/speed and occasional clr/reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      strt  = ($urandom_range(99) < 80);
      clr   = ($urandom_range(99) < 3);
      speed = 2'($urandom_range(3));
      if ($urandom_range(99) < 10) begin
        if ($urandom_range(49) == 0) delay = {1'b1, 32'($urandom), 32'($urandom)};
        else delay = W'($urandom_range(40));
      end
      if ($urandom_range(999) < 3) begin
        do_reset();
      end else begin
        run_cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
